d_memory_sync: RTL and testbench
================================

// Module: d_memory_sync
// PURPOSE
//  Parametrised single-port synchronous data memory for the pipeline MEM stage.
//  Adds a hardware clear sequencer after reset, a req/ready handshake,
//  registered read with valid flag, and out-of-range address detection.
//  All contents come from the clear sweep and runtime writes; no file I/O.
// PARAMETERS
//  DW        16    data word width (bits)
//  AW        8     address width (bits)
//  DEPTH     256   implemented words, 1..2**AW; addresses >= DEPTH are out-of-range
//  INIT_VAL  0     word value written to every location by the clear sweep
// PORTS
//  clk       in   1    single clock, all logic on posedge
//  rst       in   1    synchronous, active-high reset
//  req       in   1    access request, sampled when ready=1
//  we        in   1    1=write, 0=read; valid with req
//  addr      in   AW   word address
//  wdata     in   DW   write data
//  ready     out  1    1=accepting requests (IDLE state)
//  rdata     out  DW   read data, registered
//  rvalid    out  1    1-cycle pulse: rdata holds result of read accepted last cycle
//  addr_err  out  1    1-cycle pulse: request accepted last cycle was out-of-range
// BEHAVIOUR
//  Reset (rst=1 at posedge): state<=CLEAR, clr_ptr<=0, ready=0, rdata=0,
//   rvalid=0, addr_err=0. Array contents are not reset directly.
//  FSM states: CLEAR, IDLE.
//   CLEAR: each cycle writes INIT_VAL to mem[clr_ptr], clr_ptr++; after writing
//    DEPTH-1 go to IDLE. Takes exactly DEPTH cycles; ready=0 throughout.
//    req during CLEAR is ignored: no write, no rvalid, no addr_err.
//   IDLE: ready=1; stays in IDLE until rst.
//  Accept = req & ready at posedge.
//   Write accept, addr<DEPTH: mem[addr]<=wdata; rvalid=0 next cycle.
//   Read accept, addr<DEPTH: next cycle rdata=mem[addr], rvalid=1 (latency 1).
//   Any accept with addr>=DEPTH: write dropped; next cycle addr_err=1,
//    rvalid=0, rdata=0.
//  No accept: rvalid=0, addr_err=0, rdata holds last value.
//  Back-to-back accepts every cycle allowed; one access per cycle.
//  Write then read same address next cycle returns the new data.
//  rst during CLEAR or IDLE: restart CLEAR from clr_ptr=0; in-flight read
//   result discarded (rvalid=0 the cycle after reset).
//  clr_ptr width = clog2(DEPTH) (min 1); no wrap beyond DEPTH-1.
// CONFIGURATION
//  D_MEMORY_WRITE_FIRST_EN:
//   defined   -> port is write-first: a read accepted in the same cycle as a write to
//                the same address. Not reachable with one access per cycle, so it
//                applies to the rdata register: after a write accept, rdata updates to
//                wdata with rvalid=0 (rdata shows last written word).
//   undefined -> rdata changes only on read accepts (read-only observation).
// STRUCTURE
//  Package d_memory_pkg: default DW/AW/DEPTH, INIT_VAL, FSM state enum
//   (ST_CLEAR, ST_IDLE), clog2 helper function.
//  Sub-module d_memory_array: plain 1R1W-in-one-port storage (DEPTH x DW, sync
//   write, registered read); the top owns FSM, handshake, range check, muxing
//   clear vs. user write.
// TESTING
//  T1 reset: rst 1 cycle -> ready=0 for exactly DEPTH(256) cycles, then ready=1;
//     rvalid/addr_err=0 throughout.
//  T2 clear: INIT_VAL=16'hA5A5, read addr 0, 128, 255 -> rdata=16'hA5A5, rvalid=1
//     one cycle after each accept.
//  T3 write/read: write 16'h1234 @8'h10, next cycle read @8'h10 -> rdata=16'h1234
//     at +1; back-to-back reads @0x10,0x11 -> two consecutive rvalid pulses.
//  T4 range: DEPTH=200, write 16'hFFFF @8'd250 -> addr_err pulse, rvalid=0;
//     read @8'd250 -> addr_err=1, rdata=0; read @8'd199 unaffected.
//  T5 req during CLEAR: req=1,we=1,addr=5,wdata=16'h7777 in cycle 3 of CLEAR ->
//     ignored; after IDLE read @5 -> INIT_VAL.
//  T6 reset mid-op: rst asserted the cycle after a read accept -> rvalid=0,
//     ready=0, full DEPTH-cycle CLEAR repeats; old written data reads INIT_VAL.

Source files
------------

// File: rtl/d_memory_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the MEM-stage data memory.
package d_memory_pkg;

    localparam int unsigned DEF_DW    = 16;
    localparam int unsigned DEF_AW    = 8;
    localparam int unsigned DEF_DEPTH = 256;

    localparam logic [DEF_DW-1:0] DEF_INIT_VAL = '0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Bits needed to index n entries; never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((r < 31) && ((32'd1 << r) < n)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage : d_memory_pkg

// File: rtl/d_memory_sync_if.sv
// Request/response bus between the MEM stage and the data memory.
interface d_memory_sync_if
    import d_memory_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned AW = DEF_AW
);

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          addr_err;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata, rvalid, addr_err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata, rvalid, addr_err
    );

endinterface : d_memory_sync_if

// File: rtl/d_memory_array.sv
// Single-port DEPTH x DW storage: synchronous write, registered read data with
// synchronous clear and an optional load of the write word into the read register.
module d_memory_array #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IW    = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic          rd_byp,
    input  logic          rd_clr,
    input  logic [IW-1:0] addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    // Clear beats read beats bypass; otherwise the read register holds.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_clr) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = mem_q[addr];
        end else if (rd_byp) begin
            rd_data_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;

endmodule : d_memory_array

// File: rtl/d_memory_sync.sv
// MEM-stage data memory: post-reset clear sweep, req/ready handshake, registered
// read with valid pulse, out-of-range detection. Option: D_MEMORY_WRITE_FIRST_EN.
module d_memory_sync
    import d_memory_pkg::*;
#(
    parameter int unsigned   DW       = DEF_DW,
    parameter int unsigned   AW       = DEF_AW,
    parameter int unsigned   DEPTH    = DEF_DEPTH,
    parameter logic [DW-1:0] INIT_VAL = DW'(DEF_INIT_VAL)
) (
    input logic              clk,
    input logic              rst,
    d_memory_sync_if.slave   bus
);

    localparam int unsigned CW = clog2(DEPTH);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] clr_ptr_q;
    logic [CW-1:0] clr_ptr_d;
    logic          ready_q;
    logic          ready_d;
    logic          rvalid_q;
    logic          rvalid_d;
    logic          addr_err_q;
    logic          addr_err_d;

    logic          accept_c;
    logic          in_range_c;
    logic          last_c;
    logic          mem_wr_c;
    logic          mem_rd_c;
    logic          rd_byp_c;
    logic          rd_clr_c;
    logic [CW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;
    logic [DW-1:0] rd_data;

    assign accept_c   = bus.req & ready_q;
    assign in_range_c = (32'(bus.addr) < DEPTH);
    assign last_c     = (clr_ptr_q == CW'(DEPTH - 1));

    // Next state, clear sweep and access decode; the array port is shared
    // between the sweep and user accesses, so reset gates it off here.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        rvalid_d    = 1'b0;
        addr_err_d  = 1'b0;
        mem_wr_c    = 1'b0;
        mem_rd_c    = 1'b0;
        rd_byp_c    = 1'b0;
        rd_clr_c    = 1'b0;
        mem_addr_c  = CW'(bus.addr);
        mem_wdata_c = bus.wdata;

        case (state_q)
            ST_CLEAR: begin
                mem_wr_c    = 1'b1;
                mem_addr_c  = clr_ptr_q;
                mem_wdata_c = INIT_VAL;
                if (last_c) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + CW'(1);
                end
            end
            ST_IDLE: begin
                if (accept_c) begin
                    if (!in_range_c) begin
                        addr_err_d = 1'b1;
                        rd_clr_c   = 1'b1;
                    end else if (bus.we) begin
                        mem_wr_c = 1'b1;
`ifdef D_MEMORY_WRITE_FIRST_EN
                        rd_byp_c = 1'b1;
`else
                        rd_byp_c = 1'b0;
`endif
                    end else begin
                        mem_rd_c = 1'b1;
                        rvalid_d = 1'b1;
                    end
                end
            end
        endcase

        if (rst) begin
            mem_wr_c = 1'b0;
            mem_rd_c = 1'b0;
            rd_byp_c = 1'b0;
            rd_clr_c = 1'b1;
        end

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            ready_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            ready_q    <= ready_d;
            rvalid_q   <= rvalid_d;
            addr_err_q <= addr_err_d;
        end
    end

    d_memory_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (CW)
    ) u_array (
        .clk     (clk),
        .wr_en   (mem_wr_c),
        .rd_en   (mem_rd_c),
        .rd_byp  (rd_byp_c),
        .rd_clr  (rd_clr_c),
        .addr    (mem_addr_c),
        .wr_data (mem_wdata_c),
        .rd_data (rd_data)
    );

    assign bus.ready    = ready_q;
    assign bus.rdata    = rd_data;
    assign bus.rvalid   = rvalid_q;
    assign bus.addr_err = addr_err_q;

endmodule : d_memory_sync

// File: tb/tb_d_memory_sync.sv
// Bench for d_memory_sync: two instances (full 256-word and 200-word) driven in lock-step.
module tb_d_memory_sync;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEP_A = 256;
    localparam int unsigned DEP_B = 200;
    localparam logic [15:0] INI_A = 16'hA5A5;
    localparam logic [15:0] INI_B = 16'h5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [7:0]  addr_i = '0;
    logic [15:0] wdata_i = '0;

    d_memory_sync_if #(.DW(DW), .AW(AW)) ifa ();
    d_memory_sync_if #(.DW(DW), .AW(AW)) ifb ();

    assign ifa.req = req_i;  assign ifa.we = we_i;  assign ifa.addr = addr_i;  assign ifa.wdata = wdata_i;
    assign ifb.req = req_i;  assign ifb.we = we_i;  assign ifb.addr = addr_i;  assign ifb.wdata = wdata_i;

    d_memory_sync #(.DW(DW), .AW(AW), .DEPTH(DEP_A), .INIT_VAL(INI_A)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    d_memory_sync #(.DW(DW), .AW(AW), .DEPTH(DEP_B), .INIT_VAL(INI_B)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    always #5 clk = ~clk;

    // Reference model: a word array plus a countdown for the clear period.
    int unsigned m_dep [2];
    logic [15:0] m_ini [2];
    logic [15:0] m_mem [2][256];
    int          m_busy [2];
    bit          m_ready [2];
    bit          m_rv [2];
    bit          m_err [2];
    logic [15:0] m_rd [2];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void model_edge(input int i);
        bit acc;
        if (rst) begin
            m_busy[i]  = int'(m_dep[i]);
            m_ready[i] = 1'b0;
            m_rv[i]    = 1'b0;
            m_err[i]   = 1'b0;
            m_rd[i]    = '0;
            for (int k = 0; k < 256; k++) m_mem[i][k] = m_ini[i];
            return;
        end
        acc       = req_i && m_ready[i];
        m_rv[i]   = 1'b0;
        m_err[i]  = 1'b0;
        if (m_busy[i] > 0) begin
            m_busy[i]  = m_busy[i] - 1;
            m_ready[i] = (m_busy[i] == 0);
        end else if (acc) begin
            if (int'(addr_i) >= int'(m_dep[i])) begin
                m_err[i] = 1'b1;
                m_rd[i]  = '0;
            end else if (we_i) begin
                m_mem[i][addr_i] = wdata_i;
`ifdef D_MEMORY_WRITE_FIRST_EN
                m_rd[i] = wdata_i;
`endif
            end else begin
                m_rd[i] = m_mem[i][addr_i];
                m_rv[i] = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a.ready",    16'(ifa.ready),    16'(m_ready[0]));
        chk("a.rvalid",   16'(ifa.rvalid),   16'(m_rv[0]));
        chk("a.addr_err", 16'(ifa.addr_err), 16'(m_err[0]));
        chk("a.rdata",    ifa.rdata,         m_rd[0]);
        chk("b.ready",    16'(ifb.ready),    16'(m_ready[1]));
        chk("b.rvalid",   16'(ifb.rvalid),   16'(m_rv[1]));
        chk("b.addr_err", 16'(ifb.addr_err), 16'(m_err[1]));
        chk("b.rdata",    ifb.rdata,         m_rd[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
        req_i = r; we_i = w; addr_i = a; wdata_i = d;
    endtask

    // Counts samples with ready low, starting at the sample right after the reset edge.
    task automatic wait_clear(input bool_req_at3, output int ca, output int cb);
        ca = 0; cb = 0;
        for (int c = 0; c < 400; c++) begin
            if (ifa.ready !== 1'b1) ca++;
            if (ifb.ready !== 1'b1) cb++;
            if (ifa.ready === 1'b1 && ifb.ready === 1'b1) break;
            if (bool_req_at3 && c == 2) drive(1'b1, 1'b1, 8'd5, 16'h7777);
            else                        drive(1'b0, 1'b0, 8'd0, 16'h0000);
            step();
        end
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic        rv_a;
        logic        err_a;
        logic [15:0] rd_a;
        logic        rv_b;
        logic        err_b;
        logic [15:0] rd_b;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d,
                                input logic rva, input logic ea, input logic [15:0] rda,
                                input logic rvb, input logic eb, input logic [15:0] rdb);
        vec_t v;
        v.req = r; v.we = w; v.addr = a; v.wdata = d;
        v.rv_a = rva; v.err_a = ea; v.rd_a = rda;
        v.rv_b = rvb; v.err_b = eb; v.rd_b = rdb;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int ca;
        int cb;
        int sel;
        m_dep[0] = DEP_A; m_dep[1] = DEP_B;
        m_ini[0] = INI_A; m_ini[1] = INI_B;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_ready[i] = 1'b0; m_rv[i] = 1'b0; m_err[i] = 1'b0; m_rd[i] = '0;
        end

        // Reset, clear length, and a write during clear that must be ignored.
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 16'h0);
        step();
        rst = 1'b0;
        wait_clear(1'b1, ca, cb);
        chk("clear_len_a", 16'(ca), 16'(DEP_A));
        chk("clear_len_b", 16'(cb), 16'(DEP_B));

        // Directed table; expectations are for the sample one edge after each row.
        vecs.push_back(mk(1'b1, 1'b0, 8'd5,    16'h0000, 1'b1, 1'b0, INI_A,    1'b1, 1'b0, INI_B));
        vecs.push_back(mk(1'b1, 1'b0, 8'd0,    16'h0000, 1'b1, 1'b0, INI_A,    1'b1, 1'b0, INI_B));
        vecs.push_back(mk(1'b1, 1'b0, 8'd128,  16'h0000, 1'b1, 1'b0, INI_A,    1'b1, 1'b0, INI_B));
        vecs.push_back(mk(1'b1, 1'b0, 8'd255,  16'h0000, 1'b1, 1'b0, INI_A,    1'b0, 1'b1, 16'h0000));
        vecs.push_back(mk(1'b1, 1'b1, 8'h10,   16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b1, 1'b0, 8'h10,   16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h1234));
        vecs.push_back(mk(1'b1, 1'b0, 8'h11,   16'h0000, 1'b1, 1'b0, INI_A,    1'b1, 1'b0, INI_B));
        vecs.push_back(mk(1'b1, 1'b1, 8'd250,  16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000));
        vecs.push_back(mk(1'b1, 1'b0, 8'd250,  16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 16'h0000));
        vecs.push_back(mk(1'b1, 1'b0, 8'd199,  16'h0000, 1'b1, 1'b0, INI_A,    1'b1, 1'b0, INI_B));
        vecs.push_back(mk(1'b1, 1'b1, 8'd199,  16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b1, 1'b0, 8'd199,  16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF));
        vecs.push_back(mk(1'b0, 1'b0, 8'd199,  16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000));

        foreach (vecs[v]) begin
            drive(vecs[v].req, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            step();
            chk($sformatf("vec%0d.a.rvalid", v),   16'(ifa.rvalid),   16'(vecs[v].rv_a));
            chk($sformatf("vec%0d.a.addr_err", v), 16'(ifa.addr_err), 16'(vecs[v].err_a));
            if (vecs[v].rv_a || vecs[v].err_a) chk($sformatf("vec%0d.a.rdata", v), ifa.rdata, vecs[v].rd_a);
            chk($sformatf("vec%0d.b.rvalid", v),   16'(ifb.rvalid),   16'(vecs[v].rv_b));
            chk($sformatf("vec%0d.b.addr_err", v), 16'(ifb.addr_err), 16'(vecs[v].err_b));
            if (vecs[v].rv_b || vecs[v].err_b) chk($sformatf("vec%0d.b.rdata", v), ifb.rdata, vecs[v].rd_b);
        end

        // Randomized traffic, addresses biased to small range and both boundaries.
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       addr_i = 8'($urandom_range(0, 255));
                1:       addr_i = 8'($urandom_range(190, 210));
                2:       addr_i = 8'($urandom_range(0, 15));
                default: addr_i = 8'($urandom_range(250, 255));
            endcase
            req_i   = ($urandom_range(0, 3) != 0);
            we_i    = 1'($urandom_range(0, 1));
            wdata_i = 16'($urandom);
            step();
        end
        rst = 1'b0;
        wait_clear(1'b0, ca, cb);

        // Reset right after a read accept: result discarded, full clear repeats.
        drive(1'b1, 1'b1, 8'd20, 16'h4321);
        step();
        drive(1'b1, 1'b0, 8'd20, 16'h0000);
        step();
        chk("t6.pre.a.rdata", ifa.rdata, 16'h4321);
        chk("t6.pre.b.rdata", ifb.rdata, 16'h4321);
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'd20, 16'h0000);
        step();
        rst = 1'b0;
        chk("t6.a.rvalid", 16'(ifa.rvalid), 16'h0000);
        chk("t6.a.ready",  16'(ifa.ready),  16'h0000);
        chk("t6.b.rvalid", 16'(ifb.rvalid), 16'h0000);
        wait_clear(1'b0, ca, cb);
        chk("t6.clear_len_a", 16'(ca), 16'(DEP_A));
        chk("t6.clear_len_b", 16'(cb), 16'(DEP_B));
        drive(1'b1, 1'b0, 8'd20, 16'h0000);
        step();
        chk("t6.post.a.rvalid", 16'(ifa.rvalid), 16'h0001);
        chk("t6.post.a.rdata",  ifa.rdata,       INI_A);
        chk("t6.post.b.rdata",  ifb.rdata,       INI_B);
        drive(1'b0, 1'b0, 8'd0, 16'h0000);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_d_memory_sync
